// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter: display fetches own every slot they ask for, and one latched
// CPU access is slotted into the first cycle the display leaves free.
//
// state   | meaning
// IDLE    | nothing pending; cpu_req_i is accepted and latched
// WAIT    | CPU access latched, waiting for a cycle with no display request
// ISSUE   | CPU access is on the RAM port and is sampled at the ending edge
// CAPTURE | CPU read data is arriving from the RAM
module vdp_vram_arbiter #(
   parameter int RamBits = 16,
   parameter int MaxWait = 64
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               vdp_req_i,
   input  logic [RamBits-1:0] vdp_addr_i,
   output logic [7:0]         vdp_data_o,
   input  logic               cpu_req_i,
   input  logic               cpu_we_i,
   input  logic [RamBits-1:0] cpu_addr_i,
   input  logic [7:0]         cpu_wdata_i,
   output logic [7:0]         cpu_rdata_o,
   output logic               cpu_ack_o,
   output logic               cpu_busy_o,
   output logic               cpu_overrun_o,
   output logic [RamBits-1:0] ram_addr_o,
   output logic               ram_we_o,
   output logic [7:0]         ram_wdata_o,
   input  logic [7:0]         ram_rdata_i
);

   localparam int WaitBits = $clog2(MaxWait + 1);
   localparam logic [WaitBits-1:0] WaitLimit = WaitBits'(MaxWait);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_ISSUE   = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic               accept;
   logic               grant;
   logic               ack_set;
   logic               capture;
   logic               busy;

   logic               cpu_we_q, cpu_we_d;
   logic [RamBits-1:0] cpu_addr_q, cpu_addr_d;
   logic [7:0]         cpu_wdata_q, cpu_wdata_d;
   logic [7:0]         cpu_rdata_q, cpu_rdata_d;
   logic               cpu_ack_q, cpu_ack_d;
   logic               overrun_q, overrun_d;
   logic [WaitBits-1:0] wait_q, wait_d;
   logic [RamBits-1:0] ram_addr_q, ram_addr_d;
   logic               ram_we_q, ram_we_d;
   logic [7:0]         ram_wdata_q, ram_wdata_d;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (cpu_req_i) state_d = S_WAIT;
         S_WAIT:    if (!vdp_req_i) state_d = S_ISSUE;
         S_ISSUE:   state_d = cpu_we_q ? S_IDLE : S_CAPTURE;
         S_CAPTURE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      accept  = (state_q == S_IDLE) && cpu_req_i;
      grant   = (state_q == S_WAIT) && !vdp_req_i;
      ack_set = ((state_q == S_ISSUE) && cpu_we_q) || (state_q == S_CAPTURE);
      capture = (state_q == S_CAPTURE);
      busy    = (state_q != S_IDLE);
   end

   always_comb begin
      cpu_we_d    = cpu_we_q;
      cpu_addr_d  = cpu_addr_q;
      cpu_wdata_d = cpu_wdata_q;
      if (accept) begin
         cpu_we_d    = cpu_we_i;
         cpu_addr_d  = cpu_addr_i;
         cpu_wdata_d = cpu_wdata_i;
      end

      wait_d    = wait_q;
      overrun_d = overrun_q;
      if (accept) begin
         wait_d = '0;
      end else if ((state_q == S_WAIT) && vdp_req_i && (wait_q != WaitLimit)) begin
         wait_d = wait_q + 1'b1;
         if (wait_d == WaitLimit) overrun_d = 1'b1;
      end

      // Display always owns the slot; ram_we is only ever set by a CPU grant.
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      if (vdp_req_i) begin
         ram_addr_d = vdp_addr_i;
      end else if (grant) begin
         ram_addr_d  = cpu_addr_q;
         ram_we_d    = cpu_we_q;
         ram_wdata_d = cpu_wdata_q;
      end

      cpu_rdata_d = capture ? ram_rdata_i : cpu_rdata_q;
      cpu_ack_d   = ack_set;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         cpu_we_q    <= 1'b0;
         cpu_addr_q  <= '0;
         cpu_wdata_q <= '0;
         cpu_rdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         overrun_q   <= 1'b0;
         wait_q      <= '0;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
      end else begin
         cpu_we_q    <= cpu_we_d;
         cpu_addr_q  <= cpu_addr_d;
         cpu_wdata_q <= cpu_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_ack_q   <= cpu_ack_d;
         overrun_q   <= overrun_d;
         wait_q      <= wait_d;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign vdp_data_o    = ram_rdata_i;
   assign cpu_rdata_o   = cpu_rdata_q;
   assign cpu_ack_o     = cpu_ack_q;
   assign cpu_busy_o    = busy;
   assign cpu_overrun_o = overrun_q;
   assign ram_addr_o    = ram_addr_q;
   assign ram_we_o      = ram_we_q;
   assign ram_wdata_o   = ram_wdata_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Bench for vdp_vram_arbiter: behavioural RAM, scoreboard of expected CPU completions,
// and a display-slot monitor that checks address tracking and read data.
module tb_vdp_vram_arbiter;

   localparam int RamBits = 16;
   localparam int MaxWait = 4;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               vdp_req;
   logic [RamBits-1:0] vdp_addr;
   logic [7:0]         vdp_data;
   logic               cpu_req;
   logic               cpu_we;
   logic [RamBits-1:0] cpu_addr;
   logic [7:0]         cpu_wdata;
   logic [7:0]         cpu_rdata;
   logic               cpu_ack;
   logic               cpu_busy;
   logic               cpu_overrun;
   logic [RamBits-1:0] ram_addr;
   logic               ram_we;
   logic [7:0]         ram_wdata;
   logic [7:0]         ram_rdata = 8'h00;

   typedef struct packed {
      logic       rd;
      logic [7:0] data;
   } sb_t;

   sb_t        sb_q[$];
   logic [7:0] ref_wr [logic [15:0]];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   vdp_vram_arbiter #(.RamBits(RamBits), .MaxWait(MaxWait)) dut (
      .clk_i(clk), .reset_i(reset_n),
      .vdp_req_i(vdp_req), .vdp_addr_i(vdp_addr), .vdp_data_o(vdp_data),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_busy_o(cpu_busy),
      .cpu_overrun_o(cpu_overrun),
      .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
      .ram_rdata_i(ram_rdata)
   );

   // Behavioural single-port RAM, preloaded with addr[7:0]^addr[15:8] on its first edge.
   logic [7:0] ram_mem [0:65535];
   logic       mem_init_done = 1'b0;

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 65536; i++) ram_mem[i] <= 8'(i) ^ 8'(i >> 8);
         mem_init_done <= 1'b1;
      end else if (ram_we) begin
         ram_mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= ram_mem[ram_addr];
   end

   function automatic logic [7:0] exp_byte(input logic [15:0] a);
      if (ref_wr.exists(a)) return ref_wr[a];
      return a[7:0] ^ a[15:8];
   endfunction

   // Monitor: display slot tracking, display data, ack scoreboard, single-cycle pulses.
   logic        vq1_v = 1'b0, vq2_v = 1'b0;
   logic [15:0] vq1_a = '0, vq2_a = '0;
   logic        we_prev = 1'b0, ack_prev = 1'b0;

   always @(negedge clk) begin
      sb_t e;
      if (vq2_v) begin
         checks++;
         if (vdp_data !== exp_byte(vq2_a)) begin
            errors++;
            $display("FAIL vdp_data addr %h: got %h expected %h", vq2_a, vdp_data, exp_byte(vq2_a));
         end
      end
      if (vq1_v) begin
         checks++;
         if (ram_addr !== vq1_a || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL vdp_slot: got addr %h we %b expected addr %h we 0", ram_addr, ram_we, vq1_a);
         end
      end
      if (ram_we) begin
         checks++;
         if (we_prev) begin
            errors++;
            $display("FAIL ram_we_pulse: got 2 consecutive cycles expected 1");
         end
      end
      if (cpu_ack) begin
         checks++;
         if (ack_prev) begin
            errors++;
            $display("FAIL ack_pulse: got 2 consecutive cycles expected 1");
         end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: got ack with rdata %h expected none", cpu_rdata);
         end else begin
            e = sb_q.pop_front();
            if (e.rd && cpu_rdata !== e.data) begin
               errors++;
               $display("FAIL cpu_rdata: got %h expected %h", cpu_rdata, e.data);
            end
         end
      end
      vq2_v    = vq1_v;
      vq2_a    = vq1_a;
      vq1_v    = reset_n && vdp_req;
      vq1_a    = vdp_addr;
      we_prev  = ram_we;
      ack_prev = cpu_ack;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending after %0d cycles expected 0", sb_q.size(), budget);
         sb_q.delete();
      end
      step();
   endtask

   task automatic cpu_issue(input logic we, input logic [15:0] a, input logic [7:0] d);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = d;
      if (we) begin
         sb_q.push_back('{1'b0, 8'h00});
         ref_wr[a] = d;
      end else begin
         sb_q.push_back('{1'b1, exp_byte(a)});
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFFFF; cpu_wdata = 8'hFF;
      vdp_req = 1'b1; vdp_addr = 16'hBEEF;
      repeat (3) step();
      checks++;
      if ({ram_addr, ram_we, ram_wdata, cpu_rdata, cpu_ack, cpu_overrun, cpu_busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got addr %h we %b wd %h rd %h ack %b ovr %b busy %b expected 0",
                  ram_addr, ram_we, ram_wdata, cpu_rdata, cpu_ack, cpu_overrun, cpu_busy);
      end
      checks++;
      if (vdp_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_vdp_data: got %h expected 00", vdp_data);
      end
      reset_n = 1'b1; cpu_req = 1'b0; vdp_req = 1'b0;
      step();
      checks++;
      if (cpu_busy !== 1'b0 || cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got busy %b ack %b expected 0 0", cpu_busy, cpu_ack);
      end
   endtask

   task automatic test_free_write();
      cpu_issue(1'b1, 16'h1234, 8'hA5);
      step();
      cpu_req = 1'b0;
      checks++;
      if (cpu_busy !== 1'b1 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL wr_wait: got busy %b we %b expected 1 0", cpu_busy, ram_we);
      end
      step();
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 16'h1234 || ram_wdata !== 8'hA5 || cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL wr_issue: got we %b addr %h wd %h ack %b expected 1 1234 a5 0",
                  ram_we, ram_addr, ram_wdata, cpu_ack);
      end
      step();
      checks++;
      if (cpu_ack !== 1'b1 || ram_we !== 1'b0 || cpu_busy !== 1'b0) begin
         errors++;
         $display("FAIL wr_ack: got ack %b we %b busy %b expected 1 0 0", cpu_ack, ram_we, cpu_busy);
      end
      step();
   endtask

   task automatic test_free_read();
      cpu_issue(1'b0, 16'h1234, 8'h00);
      step();
      cpu_req = 1'b0;
      step();
      checks++;
      if (ram_addr !== 16'h1234 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL rd_issue: got addr %h we %b expected 1234 0", ram_addr, ram_we);
      end
      step();
      checks++;
      if (cpu_ack !== 1'b0 || cpu_busy !== 1'b1) begin
         errors++;
         $display("FAIL rd_capture: got ack %b busy %b expected 0 1", cpu_ack, cpu_busy);
      end
      step();
      checks++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
         errors++;
         $display("FAIL rd_ack: got ack %b rdata %h expected 1 a5", cpu_ack, cpu_rdata);
      end
      step();
      checks++;
      if (cpu_ack !== 1'b0 || cpu_rdata !== 8'hA5) begin
         errors++;
         $display("FAIL rd_hold: got ack %b rdata %h expected 0 a5", cpu_ack, cpu_rdata);
      end
   endtask

   task automatic test_contention();
      cpu_issue(1'b0, 16'h0040, 8'h00);
      for (int i = 0; i < 10; i++) begin
         vdp_req  = 1'b1;
         vdp_addr = 16'h0100 + 16'(i);
         if (i == 1) cpu_req = 1'b0;
         step();
         checks++;
         if (ram_addr !== 16'h0100 + 16'(i) || ram_we !== 1'b0 || cpu_busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_track %0d: got addr %h we %b busy %b expected %h 0 1",
                     i, ram_addr, ram_we, cpu_busy, 16'h0100 + 16'(i));
         end
      end
      vdp_req = 1'b0;
      step();
      checks++;
      if (ram_addr !== 16'h0040 || ram_we !== 1'b0 || cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL cont_grant: got addr %h we %b ack %b expected 0040 0 0", ram_addr, ram_we, cpu_ack);
      end
      step();
      step();
      checks++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h40 || cpu_overrun !== 1'b1) begin
         errors++;
         $display("FAIL cont_ack: got ack %b rdata %h ovr %b expected 1 40 1", cpu_ack, cpu_rdata, cpu_overrun);
      end
      step();
   endtask

   task automatic test_back_to_back();
      vdp_req = 1'b0;
      cpu_issue(1'b1, 16'h3000, 8'h5C);
      step();
      cpu_req = 1'b0;
      step();
      checks++;
      if (ram_addr !== 16'h3000 || ram_we !== 1'b1 || ram_wdata !== 8'h5C) begin
         errors++;
         $display("FAIL b2b_cpu_slot: got addr %h we %b wd %h expected 3000 1 5c", ram_addr, ram_we, ram_wdata);
      end
      vdp_req  = 1'b1;
      vdp_addr = 16'h2000;
      step();
      vdp_req = 1'b0;
      checks++;
      if (ram_addr !== 16'h2000 || ram_we !== 1'b0 || cpu_ack !== 1'b1) begin
         errors++;
         $display("FAIL b2b_vdp_slot: got addr %h we %b ack %b expected 2000 0 1", ram_addr, ram_we, cpu_ack);
      end
      step();
      checks++;
      if (vdp_data !== 8'h20) begin
         errors++;
         $display("FAIL b2b_vdp_data: got %h expected 20", vdp_data);
      end
      cpu_issue(1'b0, 16'h3000, 8'h00);
      step();
      cpu_req = 1'b0;
      drain(20);
   endtask

   task automatic test_req_in_ack();
      cpu_issue(1'b1, 16'h0700, 8'h11);
      step();
      cpu_addr  = 16'h0701;
      cpu_wdata = 8'hEE;
      step();
      checks++;
      if (ram_addr !== 16'h0700 || ram_wdata !== 8'h11 || ram_we !== 1'b1) begin
         errors++;
         $display("FAIL busy_ignore: got addr %h wd %h we %b expected 0700 11 1", ram_addr, ram_wdata, ram_we);
      end
      step();
      checks++;
      if (cpu_ack !== 1'b1 || cpu_busy !== 1'b0) begin
         errors++;
         $display("FAIL ack_cycle: got ack %b busy %b expected 1 0", cpu_ack, cpu_busy);
      end
      cpu_issue(1'b0, 16'h0700, 8'h00);
      step();
      cpu_req = 1'b0;
      checks++;
      if (cpu_busy !== 1'b1) begin
         errors++;
         $display("FAIL ack_cycle_accept: got busy %b expected 1", cpu_busy);
      end
      step();
      step();
      step();
      checks++;
      if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h11) begin
         errors++;
         $display("FAIL ack_cycle_read: got ack %b rdata %h expected 1 11", cpu_ack, cpu_rdata);
      end
      cpu_issue(1'b0, 16'h0701, 8'h00);
      step();
      cpu_req = 1'b0;
      drain(20);
   endtask

   task automatic test_overrun();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      checks++;
      if (cpu_overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_cleared: got %b expected 0", cpu_overrun);
      end
      cpu_issue(1'b1, 16'h0500, 8'h77);
      vdp_req  = 1'b1;
      vdp_addr = 16'h0600;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 1) cpu_req = 1'b0;
         vdp_req  = (k <= 5);
         vdp_addr = 16'h0600 + 16'(k);
         if (k == 4 || k == 5 || k >= 8) begin
            checks++;
            if (cpu_overrun !== (k >= 5)) begin
               errors++;
               $display("FAIL ovr_edge %0d: got %b expected %b", k, cpu_overrun, (k >= 5));
            end
         end
         if (k == 7) begin
            checks++;
            if (ram_we !== 1'b1 || ram_addr !== 16'h0500) begin
               errors++;
               $display("FAIL ovr_grant: got we %b addr %h expected 1 0500", ram_we, ram_addr);
            end
         end
         if (k == 8) begin
            checks++;
            if (cpu_ack !== 1'b1) begin
               errors++;
               $display("FAIL ovr_ack: got %b expected 1", cpu_ack);
            end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      vdp_req   = 1'b0;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 16'h0040;
      step();
      cpu_req = 1'b0;
      step();
      checks++;
      if (cpu_busy !== 1'b1 || ram_addr !== 16'h0040) begin
         errors++;
         $display("FAIL mid_issue: got busy %b addr %h expected 1 0040", cpu_busy, ram_addr);
      end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      checks++;
      if (cpu_busy !== 1'b0 || cpu_ack !== 1'b0 || cpu_overrun !== 1'b0 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got busy %b ack %b ovr %b we %b expected 0 0 0 0",
                  cpu_busy, cpu_ack, cpu_overrun, ram_we);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (cpu_ack !== 1'b0 || cpu_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_ack %0d: got ack %b busy %b expected 0 0", k, cpu_ack, cpu_busy);
         end
      end
      cpu_issue(1'b0, 16'h1234, 8'h00);
      step();
      cpu_req = 1'b0;
      drain(20);
   endtask

   initial begin
      reset_n = 1'b0; vdp_req = 1'b0; vdp_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      test_reset();
      test_free_write();
      test_free_read();
      test_contention();
      test_back_to_back();
      test_req_in_ack();
      test_overrun();
      test_reset_mid_read();
      drain(20);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish within 200000 time units expected finish");
      $fatal(1, "timeout");
   end

endmodule
